// File: rtl/pwm_ctrl_pkg.sv
// Register map, transaction layout and FSM states shared by the PWM register scheduler
// and its pending-write queue.
package pwm_ctrl_pkg;

   localparam int ADDR_EN_OUT_LO   = 0;
   localparam int ADDR_EN_OUT_HI   = 1;
   localparam int ADDR_EN_PWM_LO   = 2;
   localparam int ADDR_EN_PWM_HI   = 3;
   localparam int ADDR_DUTY        = 4;
   localparam int NUM_REGS         = 5;
   localparam int MAX_ADDR_DEFAULT = 4;
   localparam int TXN_WIDTH        = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_APPLY
   } state_e;

   typedef struct packed {
      logic       write;
      logic [6:0] addr;
      logic [7:0] data;
   } txn_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; full/empty come from an extra pointer
// wrap bit so every entry is usable.
module sync_fifo
   import pwm_ctrl_pkg::*;
#(
   parameter int WIDTH = TXN_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]                  wr_ptr_q, wr_ptr_d;
   logic [AW:0]                  rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push && !full) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pwm_reg_scheduler.sv
// Queues decoded SPI transactions, applies them to shadow registers one every three cycles,
// and commits the shadow set to the active PWM registers at period end (or immediately).
module pwm_reg_scheduler
   import pwm_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH       = 2,
   parameter int MAX_ADDR         = MAX_ADDR_DEFAULT,
   parameter int COMMIT_ON_PERIOD = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       txn_valid,
   input  logic       txn_write,
   input  logic [6:0] txn_addr,
   input  logic [7:0] txn_data,
   output logic       txn_ready,
   input  logic       pwm_period_end,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic [7:0] err_count,
   output logic       busy
);

   txn_t                        fifo_wdata, fifo_rdata;
   logic                        fifo_full, fifo_empty, fifo_push, fifo_pop;
   state_e                      state_q, state_d;
   txn_t                        work_q, work_d;
   logic [NUM_REGS-1:0][7:0]    shadow_q, shadow_d;
   logic [NUM_REGS-1:0][7:0]    active_q, active_d;
   logic                        dirty_q, dirty_d;
   logic [7:0]                  err_q, err_d;
   logic                        apply_write;

   assign txn_ready  = rst_n && !fifo_full;
   assign fifo_push  = txn_valid && txn_ready;
   assign fifo_wdata = '{write: txn_write, addr: txn_addr, data: txn_data};

   sync_fifo #(
      .WIDTH (TXN_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      fifo_pop    = 1'b0;
      shadow_d    = shadow_q;
      active_d    = active_q;
      dirty_d     = dirty_q;
      err_d       = err_q;
      apply_write = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               work_d   = fifo_rdata;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: state_d = ST_APPLY;
         ST_APPLY: begin
            state_d = ST_IDLE;
            if (work_q.write && int'(work_q.addr) <= MAX_ADDR && int'(work_q.addr) < NUM_REGS) begin
               apply_write = 1'b1;
            end else if (err_q != 8'hFF) begin
               err_d = err_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      for (int i = 0; i < NUM_REGS; i++) begin
         if (apply_write && work_q.addr == 7'(i)) begin
            shadow_d[i] = work_q.data;
         end
      end

      // A commit coinciding with a write takes the pre-write shadow and leaves the new data pending.
      if (COMMIT_ON_PERIOD != 0) begin
         if (pwm_period_end && dirty_q) begin
            active_d = shadow_q;
            dirty_d  = apply_write;
         end else if (apply_write) begin
            dirty_d = 1'b1;
         end
      end else begin
         active_d = shadow_d;
         dirty_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         work_q   <= '0;
         shadow_q <= '0;
         active_q <= '0;
         dirty_q  <= 1'b0;
         err_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         dirty_q  <= dirty_d;
         err_q    <= err_d;
      end
   end

   assign en_reg_out_7_0  = active_q[ADDR_EN_OUT_LO];
   assign en_reg_out_15_8 = active_q[ADDR_EN_OUT_HI];
   assign en_reg_pwm_7_0  = active_q[ADDR_EN_PWM_LO];
   assign en_reg_pwm_15_8 = active_q[ADDR_EN_PWM_HI];
   assign pwm_duty_cycle  = active_q[ADDR_DUTY];
   assign err_count       = err_q;
   assign busy            = !fifo_empty || (state_q != ST_IDLE) || dirty_q;

endmodule
